fifo_wr_ctrl_gen: RTL and testbench

//  Write-side pointer/flag controller for the async FIFO, sized by parameter instead of a fixed 4-bit lookup table.

---
 rtl/fifo_wr_ctrl_gen.sv | 103 ++++++++++
 tb/tb_fifo_wr_ctrl_gen.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl_gen.sv
// Write-side pointer and flag controller for an async FIFO, parameterised by address width.
// Produces the memory write port, the Gray write pointer and registered full/almost_full/level/overflow.
module fifo_wr_ctrl_gen #(
    parameter int ADDR_W    = 3,
    parameter int AF_THRESH = 6
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_inc,
    input  logic              clr_ovf,
    input  logic [ADDR_W:0]   sync_rptr,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W:0]   w_ptr_gray,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   w_level,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = ADDR_W + 1;
    localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
        $error("fifo_wr_ctrl_gen: AF_THRESH must be in 1..DEPTH");
    end
    if (ADDR_W < 2) begin : g_bad_addr_w
        $error("fifo_wr_ctrl_gen: ADDR_W must be at least 2");
    end

    // Gray to binary: XOR prefix running down from the MSB.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wgray;
    logic          r_full;
    logic          r_af;
    logic [PW-1:0] r_level;
    logic          r_ovf;

    logic          w_en_s;
    logic [PW-1:0] w_wbin_n;
    logic [PW-1:0] w_wgray_n;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level_n;
    logic          w_full_n;
    logic          w_af_n;

    // Next pointer, level and flag values computed from the current edge's request and read pointer.
    always_comb begin
        w_en_s    = w_inc & ~r_full;
        w_wbin_n  = r_wbin + {{(PW-1){1'b0}}, w_en_s};
        w_wgray_n = w_wbin_n ^ (w_wbin_n >> 1);
        w_rbin    = gray2bin(sync_rptr);
        w_level_n = w_wbin_n - w_rbin;
        // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
        w_full_n  = (w_wgray_n == {~sync_rptr[PW-1:PW-2], sync_rptr[PW-3:0]});
        w_af_n    = (w_level_n >= AF_T);
    end

    // Pointer and flag registers; binary and Gray pointers load together so Gray never lags.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            r_wbin  <= {PW{1'b0}};
            r_wgray <= {PW{1'b0}};
            r_full  <= 1'b0;
            r_af    <= 1'b0;
            r_level <= {PW{1'b0}};
            r_ovf   <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_n;
            r_wgray <= w_wgray_n;
            r_full  <= w_full_n;
            r_af    <= w_af_n;
            r_level <= w_level_n;
            // A write attempt while full sets overflow and beats a simultaneous clear.
            if (w_inc && r_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    assign w_en        = w_en_s;
    assign w_addr      = r_wbin[ADDR_W-1:0];
    assign w_ptr_gray  = r_wgray;
    assign full        = r_full;
    assign almost_full = r_af;
    assign w_level     = r_level;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_fifo_wr_ctrl_gen.sv
// Directed bench for fifo_wr_ctrl_gen: a count-based reference model pushes expected
// post-edge state into a queue, which is popped and compared after each rising edge.
module tb_fifo_wr_ctrl_gen;

    logic       w_clk;
    logic       w_rst;
    logic       w_inc;
    logic       clr_ovf;
    logic [3:0] sync_rptr;
    logic       w_en;
    logic [2:0] w_addr;
    logic [3:0] w_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [3:0] w_level;
    logic       overflow;

    fifo_wr_ctrl_gen #(.ADDR_W(3), .AF_THRESH(6)) dut (
        .w_clk      (w_clk),
        .w_rst      (w_rst),
        .w_inc      (w_inc),
        .clr_ovf    (clr_ovf),
        .sync_rptr  (sync_rptr),
        .w_en       (w_en),
        .w_addr     (w_addr),
        .w_ptr_gray (w_ptr_gray),
        .full       (full),
        .almost_full(almost_full),
        .w_level    (w_level),
        .overflow   (overflow)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    typedef struct packed {
        logic [3:0] gray;
        logic [2:0] addr;
        logic       full;
        logic       af;
        logic [3:0] level;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: write count modulo 16 and a sticky overflow bit.
    int   m_wcnt  = 0;
    int   m_level = 0;
    logic m_ovf   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int g2b(input logic [3:0] g);
        int b;
        b = 0;
        for (int i = 3; i >= 0; i--) begin
            b = b | ((((b >> (i + 1)) & 1) ^ int'(g[i])) << i);
        end
        return b;
    endfunction

    function automatic logic [3:0] b2g(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    // One clock: drive at the falling edge, check the combinational port, push the
    // model's prediction, then pop and compare one time unit after the rising edge.
    task automatic cyc(input logic inc, input logic clr, input logic [3:0] rp, input logic rst);
        exp_t e;
        logic mfull;
        int   acc;
        w_inc = inc; clr_ovf = clr; sync_rptr = rp; w_rst = rst;
        #1;
        mfull = (m_level == 8);
        chk("w_en", 32'(w_en), 32'(inc & ~mfull));
        chk("w_addr_pre", 32'(w_addr), 32'(m_wcnt % 8));
        if (rst) begin
            m_wcnt = 0; m_level = 0; m_ovf = 1'b0;
        end else begin
            if (inc && mfull) m_ovf = 1'b1;
            else if (clr)     m_ovf = 1'b0;
            acc     = (inc && !mfull) ? 1 : 0;
            m_wcnt  = (m_wcnt + acc) % 16;
            m_level = (m_wcnt - g2b(rp) + 16) % 16;
        end
        e.gray  = b2g(m_wcnt);
        e.addr  = 3'(m_wcnt % 8);
        e.full  = (m_level == 8);
        e.af    = (m_level >= 6);
        e.level = 4'(m_level);
        e.ovf   = m_ovf;
        q.push_back(e);
        @(posedge w_clk);
        #1;
        e = q.pop_front();
        chk("w_ptr_gray", 32'(w_ptr_gray), 32'(e.gray));
        chk("w_addr", 32'(w_addr), 32'(e.addr));
        chk("full", 32'(full), 32'(e.full));
        chk("almost_full", 32'(almost_full), 32'(e.af));
        chk("w_level", 32'(w_level), 32'(e.level));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        @(negedge w_clk);
    endtask

    logic [3:0] gray_seq [0:7];
    logic [3:0] rp;
    logic [3:0] prev_gray;
    logic       seen_wrap;
    logic       any_full;
    int         max_level;

    initial begin
        gray_seq[0] = 4'h1; gray_seq[1] = 4'h3; gray_seq[2] = 4'h2; gray_seq[3] = 4'h6;
        gray_seq[4] = 4'h7; gray_seq[5] = 4'h5; gray_seq[6] = 4'h4; gray_seq[7] = 4'hC;
        w_rst = 1'b1; w_inc = 1'b0; clr_ovf = 1'b0; sync_rptr = 4'h0;
        @(negedge w_clk);

        // Reset state, with a write request that must be ignored.
        cyc(1'b1, 1'b0, 4'h0, 1'b1);
        chk("reset_gray", 32'(w_ptr_gray), 32'h0);
        chk("reset_level", 32'(w_level), 32'h0);

        // 1: eight writes fill the FIFO; Gray sequence checked against a fixed table.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 4'h0, 1'b0);
            chk("t1_gray_seq", 32'(w_ptr_gray), 32'(gray_seq[i]));
            chk("t1_af", 32'(almost_full), (i >= 5) ? 32'h1 : 32'h0);
        end
        chk("t1_full", 32'(full), 32'h1);
        chk("t1_level", 32'(w_level), 32'h8);

        // 2: writes while full set overflow, which holds until cleared.
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        chk("t2_gray_hold", 32'(w_ptr_gray), 32'hC);
        cyc(1'b0, 1'b0, 4'h0, 1'b0);
        chk("t2_ovf_held", 32'(overflow), 32'h1);
        cyc(1'b0, 1'b1, 4'h0, 1'b0);
        chk("t2_ovf_clr", 32'(overflow), 32'h0);

        // 3: one read frees a slot, then a write refills it at address 0.
        cyc(1'b0, 1'b0, 4'b0001, 1'b0);
        chk("t3_level7", 32'(w_level), 32'h7);
        cyc(1'b1, 1'b0, 4'b0001, 1'b0);
        chk("t3_refull", 32'(full), 32'h1);

        // 4: reader tracks the writer across the pointer wrap.
        seen_wrap = 1'b0; any_full = 1'b0; max_level = 0;
        for (int i = 0; i < 17; i++) begin
            rp = b2g(m_wcnt);
            prev_gray = w_ptr_gray;
            cyc(1'b1, 1'b0, rp, 1'b0);
            if (prev_gray == 4'b1000 && w_ptr_gray == 4'b0000) seen_wrap = 1'b1;
            if (full) any_full = 1'b1;
            if (int'(w_level) > max_level) max_level = int'(w_level);
        end
        chk("t4_wrap_seen", 32'(seen_wrap), 32'h1);
        chk("t4_never_full", 32'(any_full), 32'h0);
        chk("t4_max_level", 32'(max_level), 32'h1);

        // 5: overflow set beats a same-edge clear.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, rp, 1'b0);
        chk("t5_full", 32'(full), 32'h1);
        cyc(1'b1, 1'b1, rp, 1'b0);
        chk("t5_set_wins", 32'(overflow), 32'h1);

        // 6: reset mid-operation at level 5, then the first write goes to address 0.
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 4'h0, 1'b0);
        chk("t6_level5", 32'(w_level), 32'h5);
        cyc(1'b1, 1'b0, 4'h0, 1'b1);
        chk("t6_rst_level", 32'(w_level), 32'h0);
        chk("t6_rst_addr", 32'(w_addr), 32'h0);
        chk("t6_rst_ovf", 32'(overflow), 32'h0);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        chk("t6_first_write", 32'(w_addr), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
